// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: operation encoding, FSM states
// and the SHIFT-direction constants.
package alu_pkg;

    localparam logic [2:0] ALU_FWD   = 3'b000;
    localparam logic [2:0] ALU_ADD   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_MUL   = 3'b100;
    localparam logic [2:0] ALU_SRA   = 3'b101;
    localparam logic [2:0] ALU_ROR   = 3'b110;
    localparam logic [2:0] ALU_SHIFT = 3'b111;

    localparam logic SH_LEFT  = 1'b0;
    localparam logic SH_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } alu_state_t;

endpackage

// File: rtl/alu_seq_mul.sv
// Shift-add multiplier: one multiplier bit per cycle, LSB first, exactly WIDTH
// steps after i_start, then a one-cycle o_done pulse with the full product.
module alu_seq_mul #(
    parameter int WIDTH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    output logic                 o_done,
    output logic [2*WIDTH-1:0]   o_product
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    logic               r_busy;
    logic               r_done;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;

    // r_mcand holds DATA1 << i for the current step i; r_mplier[0] is DATA2[i]
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_busy   <= 1'b1;
                r_cnt    <= '0;
                r_acc    <= '0;
                r_mcand  <= {{WIDTH{1'b0}}, i_a};
                r_mplier <= i_b;
            end else if (r_busy) begin
                if (r_mplier[0]) begin
                    r_acc <= r_acc + r_mcand;
                end
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + 1'b1;
                if (r_cnt == LAST_STEP) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_done    = r_done;
    assign o_product = r_acc;

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with valid/ready handshake on both sides, registered
// result/flags and a sequential multiplier; one operation in flight at a time.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [2:0]       i_select,
    input  logic [WIDTH-1:0] i_data1,
    input  logic [WIDTH-1:0] i_data2,
    input  logic [SHW-1:0]   i_shift,
    input  logic             i_choice,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_result,
    output logic             o_zero,
    output logic             o_carry
);

    localparam logic [SHW-1:0] W_AMT = SHW'(WIDTH);

    alu_state_t         r_state, w_state_next;
    logic [2:0]         r_sel;
    logic [WIDTH-1:0]   r_d1, r_d2;
    logic [SHW-1:0]     r_shift;
    logic               r_choice;
    logic [WIDTH-1:0]   r_result;
    logic               r_carry;
    logic               r_out_valid;

    logic               w_accept;
    logic               w_mul_start;
    logic               w_mul_done;
    logic [2*WIDTH-1:0] w_product;
    logic [WIDTH:0]     w_sum;
    logic               w_big;
    logic [SHW-1:0]     w_rot;
    logic [WIDTH-1:0]   w_alu_result;
    logic               w_alu_carry;

    assign o_in_ready  = (r_state == IDLE);
    assign w_accept    = i_in_valid && o_in_ready;
    assign w_mul_start = w_accept && (i_select == ALU_MUL);

    // The multiplier latches its operands itself so its first step lands on the next edge
    alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_start   (w_mul_start),
        .i_a       (i_data1),
        .i_b       (i_data2),
        .o_done    (w_mul_done),
        .o_product (w_product)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (i_in_valid) w_state_next = (i_select == ALU_MUL) ? MUL : DONE;
            MUL:  if (w_mul_done) w_state_next = DONE;
            DONE: if (r_out_valid && i_out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sel    <= '0;
            r_d1     <= '0;
            r_d2     <= '0;
            r_shift  <= '0;
            r_choice <= 1'b0;
        end else if (w_accept) begin
            r_sel    <= i_select;
            r_d1     <= i_data1;
            r_d2     <= i_data2;
            r_shift  <= i_shift;
            r_choice <= i_choice;
        end
    end

    // Single-cycle ops work only on the captured operands
    always_comb begin
        w_sum        = {1'b0, r_d1} + {1'b0, r_d2};
        w_big        = (r_shift >= W_AMT);
        w_rot        = r_shift % W_AMT;
        w_alu_result = '0;
        w_alu_carry  = 1'b0;
        case (r_sel)
            ALU_FWD: w_alu_result = r_d2;
            ALU_ADD: begin
                w_alu_result = w_sum[WIDTH-1:0];
                w_alu_carry  = w_sum[WIDTH];
            end
            ALU_AND: w_alu_result = r_d1 & r_d2;
            ALU_OR:  w_alu_result = r_d1 | r_d2;
            ALU_SRA: w_alu_result = w_big ? {WIDTH{r_d1[WIDTH-1]}}
                                          : WIDTH'($signed(r_d1) >>> r_shift);
            ALU_ROR: w_alu_result = (r_d1 >> w_rot) | (r_d1 << (WIDTH - int'(w_rot)));
            ALU_SHIFT: begin
                if (!w_big) begin
                    w_alu_result = (r_choice == SH_RIGHT) ? (r_d1 >> r_shift)
                                                          : (r_d1 << r_shift);
                end
            end
            default: ;
        endcase
    end

    // Non-MUL results load on the first DONE cycle; MUL results load on o_done
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_result    <= '0;
            r_carry     <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                MUL: begin
                    if (w_mul_done) begin
                        r_result    <= w_product[WIDTH-1:0];
                        r_carry     <= |w_product[2*WIDTH-1:WIDTH];
                        r_out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (!r_out_valid) begin
                        r_result    <= w_alu_result;
                        r_carry     <= w_alu_carry;
                        r_out_valid <= 1'b1;
                    end else if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_result    = r_result;
    assign o_zero      = (r_result == '0);
    assign o_carry     = r_carry;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: WIDTH=8 directed vectors, backpressure and
// reset-mid-MUL scenarios, plus a WIDTH=16 instance with a reference model.
module tb_alu_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // WIDTH = 8 instance
    logic       in_valid, in_ready, out_valid, out_ready, choice, zero, carry;
    logic [2:0] sel;
    logic [7:0] d1, d2, result;
    logic [3:0] sh;

    alu_seq #(.WIDTH(8)) dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_select(sel), .i_data1(d1), .i_data2(d2), .i_shift(sh), .i_choice(choice),
        .o_out_valid(out_valid), .i_out_ready(out_ready), .o_result(result),
        .o_zero(zero), .o_carry(carry)
    );

    // WIDTH = 16 instance
    logic        in_valid_w, in_ready_w, out_valid_w, out_ready_w, choice_w, zero_w, carry_w;
    logic [2:0]  sel_w;
    logic [15:0] d1_w, d2_w, result_w;
    logic [4:0]  sh_w;

    alu_seq #(.WIDTH(16)) dut16 (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid_w), .o_in_ready(in_ready_w),
        .i_select(sel_w), .i_data1(d1_w), .i_data2(d2_w), .i_shift(sh_w), .i_choice(choice_w),
        .o_out_valid(out_valid_w), .i_out_ready(out_ready_w), .o_result(result_w),
        .o_zero(zero_w), .o_carry(carry_w)
    );

    typedef struct {
        logic [15:0] res;
        logic        cy;
        int          lat;
        int          acc;
    } exp_t;

    exp_t q8[$];
    exp_t q16[$];

    typedef struct packed {
        logic [2:0] s;
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] n;
        logic       c;
        logic [7:0] r;
        logic       cy;
    } vec8_t;

    vec8_t vecs[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Monitors: latency checked when OUT_VALID rises, data checked on the handshake
    logic ov_prev8 = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            ov_prev8 <= 1'b0;
        end else begin
            if (out_valid && !ov_prev8) begin
                if (q8.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected8: out_valid with result %0h, none required", result);
                end else begin
                    chk("latency8", cyc - q8[0].acc, q8[0].lat);
                end
            end
            if (out_valid && out_ready && q8.size() != 0) begin
                e = q8.pop_front();
                $display("dut8  txn result=%02h zero=%b carry=%b (expect %02h/%b/%b)",
                         result, zero, carry, e.res[7:0], (e.res == 16'd0), e.cy);
                chk("result8", result, e.res);
                chk("zero8", zero, (e.res == 16'd0));
                chk("carry8", carry, e.cy);
            end
            ov_prev8 <= out_valid;
        end
    end

    logic ov_prev16 = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            ov_prev16 <= 1'b0;
        end else begin
            if (out_valid_w && !ov_prev16) begin
                if (q16.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected16: out_valid with result %0h, none required", result_w);
                end else begin
                    chk("latency16", cyc - q16[0].acc, q16[0].lat);
                end
            end
            if (out_valid_w && out_ready_w && q16.size() != 0) begin
                e = q16.pop_front();
                $display("dut16 txn result=%04h zero=%b carry=%b (expect %04h/%b/%b)",
                         result_w, zero_w, carry_w, e.res, (e.res == 16'd0), e.cy);
                chk("result16", result_w, e.res);
                chk("zero16", zero_w, (e.res == 16'd0));
                chk("carry16", carry_w, e.cy);
            end
            ov_prev16 <= out_valid_w;
        end
    end

    task automatic send8(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] n, input logic c, output int acc);
        int w = 0;
        while (!in_ready && w < 100) begin @(posedge clk); #1; w++; end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL accept8: in_ready got %b required 1 within 100 cycles", in_ready);
        end
        sel = s; d1 = a; d2 = b; sh = n; choice = c; in_valid = 1'b1;
        @(posedge clk); #1;
        acc = cyc;
        in_valid = 1'b0;
    endtask

    task automatic send16(input logic [2:0] s, input logic [15:0] a, input logic [15:0] b,
                          input logic [4:0] n, input logic c, output int acc);
        int w = 0;
        while (!in_ready_w && w < 100) begin @(posedge clk); #1; w++; end
        if (!in_ready_w) begin
            checks++; errors++;
            $display("FAIL accept16: in_ready got %b required 1 within 100 cycles", in_ready_w);
        end
        sel_w = s; d1_w = a; d2_w = b; sh_w = n; choice_w = c; in_valid_w = 1'b1;
        @(posedge clk); #1;
        acc = cyc;
        in_valid_w = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while ((q8.size() != 0 || q16.size() != 0) && w < 300) begin @(posedge clk); w++; end
        #1;
        chk("drain8", q8.size(), 0);
        chk("drain16", q16.size(), 0);
    endtask

    // Independent WIDTH=16 reference: {carry, result}
    function automatic logic [16:0] model16(input logic [2:0] s, input logic [15:0] a,
                                            input logic [15:0] b, input logic [4:0] n,
                                            input logic c);
        logic [31:0] p;
        logic [15:0] r;
        logic        cy;
        int          m;
        r = '0; cy = 1'b0;
        case (s)
            3'd0: r = b;
            3'd1: {cy, r} = a + b;
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: begin p = a * b; r = p[15:0]; cy = |p[31:16]; end
            3'd5: r = (n >= 5'd16) ? {16{a[15]}} : 16'($signed(a) >>> n);
            3'd6: begin
                m = int'(n) % 16;
                p = (32'(a) >> m) | (32'(a) << (16 - m));
                r = p[15:0];
            end
            default: r = (n >= 5'd16) ? 16'd0 : (c ? (a >> n) : (a << n));
        endcase
        return {cy, r};
    endfunction

    initial begin
        int          acc;
        logic [16:0] m;
        logic [2:0]  rs;
        logic [15:0] ra, rb;
        logic [4:0]  rn;
        logic        rc;

        //            op     DATA1  DATA2  SHIFT CHOICE RESULT CARRY
        vecs[0]  = '{3'd1, 8'd200, 8'd100, 4'd0,  1'b0, 8'd44,  1'b1};
        vecs[1]  = '{3'd4, 8'd3,   8'd7,   4'd0,  1'b0, 8'd21,  1'b0};
        vecs[2]  = '{3'd4, 8'd16,  8'd16,  4'd0,  1'b0, 8'd0,   1'b1};
        vecs[3]  = '{3'd5, 8'h90,  8'h00,  4'd2,  1'b0, 8'hE4,  1'b0};
        vecs[4]  = '{3'd5, 8'h90,  8'h00,  4'd9,  1'b0, 8'hFF,  1'b0};
        vecs[5]  = '{3'd6, 8'h0E,  8'h00,  4'd10, 1'b0, 8'h83,  1'b0};
        vecs[6]  = '{3'd7, 8'h81,  8'h00,  4'd8,  1'b0, 8'h00,  1'b0};
        vecs[7]  = '{3'd7, 8'h81,  8'h00,  4'd1,  1'b0, 8'h02,  1'b0};
        vecs[8]  = '{3'd7, 8'h81,  8'h00,  4'd3,  1'b1, 8'h10,  1'b0};
        vecs[9]  = '{3'd7, 8'h81,  8'h00,  4'd0,  1'b1, 8'h81,  1'b0};
        vecs[10] = '{3'd0, 8'h12,  8'h34,  4'd5,  1'b0, 8'h34,  1'b0};
        vecs[11] = '{3'd2, 8'hF0,  8'h3C,  4'd0,  1'b0, 8'h30,  1'b0};
        vecs[12] = '{3'd3, 8'hF0,  8'h3C,  4'd0,  1'b0, 8'hFC,  1'b0};
        vecs[13] = '{3'd1, 8'hFF,  8'h01,  4'd0,  1'b0, 8'h00,  1'b1};
        vecs[14] = '{3'd4, 8'hFF,  8'hFF,  4'd0,  1'b0, 8'h01,  1'b1};
        vecs[15] = '{3'd6, 8'h0E,  8'h00,  4'd0,  1'b0, 8'h0E,  1'b0};
        vecs[16] = '{3'd5, 8'h40,  8'h00,  4'd3,  1'b0, 8'h08,  1'b0};
        vecs[17] = '{3'd7, 8'h81,  8'h00,  4'd15, 1'b1, 8'h00,  1'b0};
        vecs[18] = '{3'd6, 8'h0E,  8'h00,  4'd8,  1'b0, 8'h0E,  1'b0};
        vecs[19] = '{3'd5, 8'h90,  8'h00,  4'd8,  1'b0, 8'hFF,  1'b0};

        rst_n = 1'b0;
        in_valid = 1'b0; sel = '0; d1 = '0; d2 = '0; sh = '0; choice = 1'b0; out_ready = 1'b1;
        in_valid_w = 1'b0; sel_w = '0; d1_w = '0; d2_w = '0; sh_w = '0; choice_w = 1'b0;
        out_ready_w = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_zero", zero, 1);
        chk("rst_carry", carry, 0);
        chk("rst_out_valid16", out_valid_w, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            send8(vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].n, vecs[i].c, acc);
            q8.push_back('{res: 16'(vecs[i].r), cy: vecs[i].cy,
                           lat: (vecs[i].s == 3'd4) ? 9 : 1, acc: acc});
        end
        drain();

        // Backpressure: result held for 3 cycles, a waiting op is refused until after the handshake
        out_ready = 1'b0;
        send8(3'd1, 8'd200, 8'd100, 4'd0, 1'b0, acc);
        q8.push_back('{res: 16'd44, cy: 1'b1, lat: 1, acc: acc});
        sel = 3'd1; d1 = 8'd5; d2 = 8'd6; sh = '0; choice = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_result", result, 8'd44);
        end
        out_ready = 1'b1;
        send8(3'd1, 8'd5, 8'd6, 4'd0, 1'b0, acc);
        q8.push_back('{res: 16'd11, cy: 1'b0, lat: 1, acc: acc});
        drain();

        // Reset during a multiply discards it
        send8(3'd4, 8'd5, 8'd5, 4'd0, 1'b0, acc);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rstmul_out_valid", out_valid, 0);
        chk("rstmul_in_ready", in_ready, 1);
        chk("rstmul_result", result, 0);
        chk("rstmul_zero", zero, 1);
        chk("rstmul_carry", carry, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        send8(3'd1, 8'd1, 8'd1, 4'd0, 1'b0, acc);
        q8.push_back('{res: 16'd2, cy: 1'b0, lat: 1, acc: acc});
        drain();

        // WIDTH = 16
        send16(3'd4, 16'd300, 16'd300, 5'd0, 1'b0, acc);
        q16.push_back('{res: 16'h5F90, cy: 1'b1, lat: 17, acc: acc});
        send16(3'd5, 16'h8000, 16'h0000, 5'd16, 1'b0, acc);
        q16.push_back('{res: 16'hFFFF, cy: 1'b0, lat: 1, acc: acc});
        for (int i = 0; i < 10; i++) begin
            rs = 3'($urandom_range(0, 7));
            ra = 16'($urandom);
            rb = 16'($urandom);
            rn = 5'($urandom_range(0, 31));
            rc = 1'($urandom_range(0, 1));
            m = model16(rs, ra, rb, rn, rc);
            send16(rs, ra, rb, rn, rc, acc);
            q16.push_back('{res: m[15:0], cy: m[16], lat: (rs == 3'd4) ? 17 : 1, acc: acc});
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
